// File: rtl/ramped_reg_gate.sv
// Per-channel gain gate that ramps each channel's gain between 0 and full scale, one step every ramp_rate cycles.
// Optional macro RAMPED_REG_GATE_EXTTRIG_EN qualifies every channel enable with a synchronized exttrig.
module ramped_reg_gate #(
  parameter int NCH    = 4,
  parameter int WIDTH  = 16,
  parameter int GAIN_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic [NCH-1:0]         gate_en,
  input  logic [15:0]            ramp_rate,
  input  logic                   exttrig,
  output logic [NCH*WIDTH-1:0]   dout,
  output logic [2*NCH-1:0]       state,
  output logic                   busy
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_DOWN = 2'd3;

  localparam logic [GAIN_W:0] FULL   = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [GAIN_W:0] FULLM1 = {1'b0, {GAIN_W{1'b1}}};
  localparam logic [GAIN_W:0] ONE    = {{GAIN_W{1'b0}}, 1'b1};
  localparam int              PW     = WIDTH + GAIN_W + 2;

  logic [NCH-1:0] en;

`ifdef RAMPED_REG_GATE_EXTTRIG_EN
  logic trig_s1, trig_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
    end else begin
      trig_s1 <= exttrig;
      trig_s2 <= trig_s1;
    end
  end

  assign en = gate_en & {NCH{trig_s2}};
`else
  logic unused_exttrig;
  assign unused_exttrig = exttrig;
  assign en = gate_en;
`endif

  logic [1:0]      st    [NCH];
  logic [1:0]      st_n  [NCH];
  logic [GAIN_W:0] g     [NCH];
  logic [GAIN_W:0] g_n   [NCH];
  logic [15:0]     cnt   [NCH];
  logic [15:0]     cnt_n [NCH];
  logic [NCH-1:0]  step;
  logic            bypass;
  logic            busy_n;

  assign bypass = (ramp_rate == 16'd0);

  // The compare is ">=" so a counter left above a freshly lowered ramp_rate steps immediately.
  for (genvar k = 0; k < NCH; k++) begin : g_step
    assign step[k] = ({1'b0, cnt[k]} + 17'd1) >= {1'b0, ramp_rate};
  end

  // Reversal has priority over stepping, so direction changes keep the current gain.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      st_n[k]  = st[k];
      g_n[k]   = g[k];
      cnt_n[k] = cnt[k];
      case (st[k])
        S_OFF: begin
          if (en[k]) begin
            if (bypass) begin
              st_n[k] = S_ON;
              g_n[k]  = FULL;
            end else begin
              st_n[k]  = S_UP;
              cnt_n[k] = '0;
            end
          end
        end
        S_UP: begin
          if (!en[k]) begin
            st_n[k]  = S_DOWN;
            cnt_n[k] = '0;
          end else if (g[k] == FULL) begin
            st_n[k]  = S_ON;
            cnt_n[k] = '0;
          end else if (step[k]) begin
            g_n[k]   = g[k] + ONE;
            cnt_n[k] = '0;
            if (g[k] == FULLM1) st_n[k] = S_ON;
          end else begin
            cnt_n[k] = cnt[k] + 16'd1;
          end
        end
        S_ON: begin
          if (!en[k]) begin
            if (bypass) begin
              st_n[k] = S_OFF;
              g_n[k]  = '0;
            end else begin
              st_n[k]  = S_DOWN;
              cnt_n[k] = '0;
            end
          end
        end
        S_DOWN: begin
          if (en[k]) begin
            st_n[k]  = S_UP;
            cnt_n[k] = '0;
          end else if (g[k] == '0) begin
            st_n[k]  = S_OFF;
            cnt_n[k] = '0;
          end else if (step[k]) begin
            g_n[k]   = g[k] - ONE;
            cnt_n[k] = '0;
            if (g[k] == ONE) st_n[k] = S_OFF;
          end else begin
            cnt_n[k] = cnt[k] + 16'd1;
          end
        end
        default: begin
          st_n[k] = S_OFF;
        end
      endcase
    end
  end

  // Bit 0 of the encoding is set exactly in the two ramping states.
  always_comb begin
    busy_n = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      busy_n = busy_n | st_n[k][0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        st[k]  <= S_OFF;
        g[k]   <= '0;
        cnt[k] <= '0;
      end
      busy <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        st[k]  <= st_n[k];
        g[k]   <= g_n[k];
        cnt[k] <= cnt_n[k];
      end
      busy <= busy_n;
    end
  end

  // Full-scale gain is an exact power of two, so ON passes din unchanged and OFF gives 0.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    logic signed [WIDTH-1:0] x;
    logic signed [PW-1:0]    xe;
    logic signed [PW-1:0]    ge;
    logic signed [PW-1:0]    prod;
    logic        [WIDTH-1:0] y;

    assign x  = din[k*WIDTH +: WIDTH];
    assign xe = PW'(x);
    assign ge = PW'($signed({1'b0, g[k]}));

    always_ff @(posedge clk) begin
      if (reset) begin
        prod <= '0;
        y    <= '0;
      end else begin
        prod <= xe * ge;
        y    <= WIDTH'(prod >>> GAIN_W);
      end
    end

    assign dout[k*WIDTH +: WIDTH] = y;
    assign state[2*k +: 2]        = st[k];
  end

endmodule

// File: tb/tb_ramped_reg_gate.sv
// Self-checking bench for ramped_reg_gate: directed ramp scenarios plus randomized traffic
// checked against a gain/direction reference model.
module tb_ramped_reg_gate;

  localparam int NCH    = 4;
  localparam int WIDTH  = 16;
  localparam int GAIN_W = 8;
  localparam int FULL   = 1 << GAIN_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH*WIDTH-1:0] din;
  logic [NCH-1:0]       gate_en;
  logic [15:0]          ramp_rate;
  logic                 exttrig;
  logic [NCH*WIDTH-1:0] dout;
  logic [2*NCH-1:0]     state;
  logic                 busy;

  always #5 clk = ~clk;

  ramped_reg_gate #(.NCH(NCH), .WIDTH(WIDTH), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .reset(reset), .din(din), .gate_en(gate_en),
    .ramp_rate(ramp_rate), .exttrig(exttrig),
    .dout(dout), .state(state), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Model: gain level, whether it is moving and in which direction, cycles waited since last step.
  int     m_g    [NCH];
  int     m_cnt  [NCH];
  bit     m_mov  [NCH];
  int     m_dir  [NCH];
  longint m_prod [NCH];
  int     m_dout [NCH];
  bit     m_s1, m_s2;

  logic [NCH*WIDTH-1:0] exp_dout;
  logic [2*NCH-1:0]     exp_state;
  logic                 exp_busy;

  function automatic int din_of(int k);
    logic signed [WIDTH-1:0] v;
    v = din[k*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  task automatic model_step();
    bit en;
    int rate;
    int target;
    logic [31:0] t;
    rate = int'(ramp_rate);
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        m_g[k] = 0; m_cnt[k] = 0; m_mov[k] = 0; m_dir[k] = 0;
        m_prod[k] = 0; m_dout[k] = 0;
      end
      m_s1 = 0; m_s2 = 0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        en = gate_en[k];
`ifdef RAMPED_REG_GATE_EXTTRIG_EN
        en = en && m_s2;
`endif
        m_dout[k] = int'(m_prod[k] >>> GAIN_W);
        m_prod[k] = longint'(din_of(k)) * longint'(m_g[k]);
        target = en ? FULL : 0;
        if (!m_mov[k]) begin
          if (m_g[k] != target) begin
            if (rate == 0) m_g[k] = target;
            else begin
              m_mov[k] = 1; m_dir[k] = en ? 1 : -1; m_cnt[k] = 0;
            end
          end
        end else if ((m_dir[k] > 0) != en) begin
          m_dir[k] = -m_dir[k]; m_cnt[k] = 0;
        end else if (m_g[k] == target) begin
          m_mov[k] = 0;
        end else if (m_cnt[k] + 1 >= rate) begin
          m_g[k] = m_g[k] + m_dir[k];
          m_cnt[k] = 0;
          if (m_g[k] == target) m_mov[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = exttrig;
    end
    exp_busy = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      t = m_dout[k];
      exp_dout[k*WIDTH +: WIDTH] = t[WIDTH-1:0];
      exp_state[2*k +: 2] = m_mov[k] ? (m_dir[k] > 0 ? 2'd1 : 2'd3) : (m_g[k] == FULL ? 2'd2 : 2'd0);
      if (m_mov[k]) exp_busy = 1'b1;
    end
  endtask

  // One clock: the model consumes the inputs seen at the edge, outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; gate_en = '0; ramp_rate = 16'd1; exttrig = 1'b0;
    din = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) tick();
    if (state !== '0) begin errors++; $display("[TB] FAIL reset_state got=%h want=0", state); end
    checks++;
    if (dout !== '0) begin errors++; $display("[TB] FAIL reset_dout got=%h want=0", dout); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++;
    reset = 1'b0;
  endtask

  task automatic test_ramp_up();
    int n;
    int prev;
    logic signed [WIDTH-1:0] d0;
    do_reset();
    ramp_rate = 16'd1;
    din = '0;
    din[0 +: WIDTH] = 16'd1000;
    gate_en = 4'b0001;
    n = 0; prev = 0;
    while (state[1:0] !== 2'd2 && n < 400) begin
      tick(); n++;
      d0 = dout[0 +: WIDTH];
      if (state !== exp_state) begin errors++; $display("[TB] FAIL up_state cyc=%0d got=%h want=%h", n, state, exp_state); end
      checks++;
      if (dout !== exp_dout) begin errors++; $display("[TB] FAIL up_dout cyc=%0d got=%h want=%h", n, dout, exp_dout); end
      checks++;
      if (busy !== exp_busy) begin errors++; $display("[TB] FAIL up_busy cyc=%0d got=%b want=%b", n, busy, exp_busy); end
      checks++;
      if (int'(d0) < prev) begin errors++; $display("[TB] FAIL up_monotonic cyc=%0d got=%0d prev=%0d", n, d0, prev); end
      checks++;
      prev = int'(d0);
    end
    // One edge to leave OFF, then 256 unit steps.
    if (n != 257) begin errors++; $display("[TB] FAIL up_on_cycle got=%0d want=257", n); end
    checks++;
    tick(); tick();
    if (dout[0 +: WIDTH] !== 16'd1000) begin errors++; $display("[TB] FAIL up_on_exact got=%0d want=1000", $signed(dout[0 +: WIDTH])); end
    checks++;
  endtask

  task automatic test_ramp_down();
    int n;
    do_reset();
    ramp_rate = 16'd4;
    din = '0;
    din[0 +: WIDTH] = 16'd1000;
    gate_en = 4'b0001;
    n = 0;
    while (m_g[0] != 100 && n < 1000) begin
      tick(); n++;
      if (dout !== exp_dout) begin errors++; $display("[TB] FAIL down_rise_dout cyc=%0d got=%h want=%h", n, dout, exp_dout); end
      checks++;
    end
    gate_en = 4'b0000;
    n = 0;
    while (state[1:0] !== 2'd0 && n < 600) begin
      tick(); n++;
      if (state !== exp_state) begin errors++; $display("[TB] FAIL down_state cyc=%0d got=%h want=%h", n, state, exp_state); end
      checks++;
      if (dout !== exp_dout) begin errors++; $display("[TB] FAIL down_dout cyc=%0d got=%h want=%h", n, dout, exp_dout); end
      checks++;
    end
    // One reversal edge, then 100 steps of 4 cycles each.
    if (n != 401) begin errors++; $display("[TB] FAIL down_off_cycle got=%0d want=401", n); end
    checks++;
    tick(); tick();
    if (dout[0 +: WIDTH] !== '0) begin errors++; $display("[TB] FAIL down_dout_zero got=%0d want=0", $signed(dout[0 +: WIDTH])); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL down_busy got=%b want=0", busy); end
    checks++;
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] want [3];
    do_reset();
    ramp_rate = 16'd0;
    din = '0;
    din[WIDTH +: WIDTH] = 16'h8000;
    for (int r = 0; r < 2; r++) begin
      gate_en = (r == 0) ? 4'b0010 : 4'b0000;
      want[0] = (r == 0) ? 16'h0000 : 16'h8000;
      want[1] = want[0];
      want[2] = (r == 0) ? 16'h8000 : 16'h0000;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (dout[WIDTH +: WIDTH] !== want[i]) begin errors++; $display("[TB] FAIL bypass_dout r=%0d i=%0d got=%h want=%h", r, i, dout[WIDTH +: WIDTH], want[i]); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bypass_busy r=%0d i=%0d got=%b want=0", r, i, busy); end
        checks++;
      end
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(2) == 0) gate_en[1] = ~gate_en[1];
      tick();
      if (dout !== exp_dout) begin errors++; $display("[TB] FAIL bypass_rand_dout i=%0d got=%h want=%h", i, dout, exp_dout); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bypass_rand_busy i=%0d got=%b want=0", i, busy); end
      checks++;
    end
  endtask

  task automatic test_arith();
    int n;
    do_reset();
    ramp_rate = 16'd1;
    din = '0;
    din[0 +: WIDTH] = 16'hFFFD;
    gate_en = 4'b0001;
    n = 0;
    while (m_g[0] != 128 && n < 300) begin tick(); n++; end
    ramp_rate = 16'hFFFF;
    tick(); tick(); tick();
    if (dout[0 +: WIDTH] !== 16'hFFFE) begin errors++; $display("[TB] FAIL arith_neg got=%0d want=-2", $signed(dout[0 +: WIDTH])); end
    checks++;
    din[0 +: WIDTH] = 16'd3;
    tick(); tick();
    if (dout[0 +: WIDTH] !== 16'd1) begin errors++; $display("[TB] FAIL arith_pos got=%0d want=1", $signed(dout[0 +: WIDTH])); end
    checks++;
    if (dout !== exp_dout) begin errors++; $display("[TB] FAIL arith_model got=%h want=%h", dout, exp_dout); end
    checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ramp_rate = 16'd2;
    din = {$urandom, $urandom};
    gate_en = 4'b0101;
    for (int i = 0; i < 60; i++) tick();
    reset = 1'b1;
    tick();
    if (state !== '0) begin errors++; $display("[TB] FAIL midreset_state got=%h want=0", state); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got=%b want=0", busy); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      if (dout !== '0) begin errors++; $display("[TB] FAIL midreset_dout i=%0d got=%h want=0", i, dout); end
      checks++;
      if (i < 2) tick();
    end
    reset = 1'b0;
    tick();
    if (state !== 8'b0001_0001) begin errors++; $display("[TB] FAIL midreset_restart got=%b want=00010001", state); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_restart_busy got=%b want=1", busy); end
    checks++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dout !== exp_dout) begin errors++; $display("[TB] FAIL midreset_dout_ramp i=%0d got=%h want=%h", i, dout, exp_dout); end
      checks++;
    end
  endtask

  task automatic test_random();
    int rates [5] = '{0, 1, 1, 2, 3};
    do_reset();
    ramp_rate = 16'd1;
    for (int i = 0; i < 3000; i++) begin
      din = {$urandom, $urandom};
      exttrig = 1'($urandom_range(1));
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(299) == 0) gate_en[k] = ~gate_en[k];
      if ($urandom_range(399) == 0) ramp_rate = 16'(rates[$urandom_range(4)]);
      reset = ($urandom_range(999) == 0);
      tick();
      if (state !== exp_state) begin errors++; $display("[TB] FAIL rand_state i=%0d got=%h want=%h", i, state, exp_state); end
      checks++;
      if (dout !== exp_dout) begin errors++; $display("[TB] FAIL rand_dout i=%0d got=%h want=%h", i, dout, exp_dout); end
      checks++;
      if (busy !== exp_busy) begin errors++; $display("[TB] FAIL rand_busy i=%0d got=%b want=%b", i, busy, exp_busy); end
      checks++;
    end
    reset = 1'b0;
    exttrig = 1'b0;
  endtask

`ifdef RAMPED_REG_GATE_EXTTRIG_EN
  task automatic test_exttrig();
    int n;
    exttrig = 1'b0;
    do_reset();
    ramp_rate = 16'd1;
    gate_en = 4'b0001;
    tick(); tick();
    if (state[1:0] !== 2'd0) begin errors++; $display("[TB] FAIL trig_blocked got=%0d want=0", state[1:0]); end
    checks++;
    exttrig = 1'b1;
    tick(); tick();
    if (state[1:0] !== 2'd0) begin errors++; $display("[TB] FAIL trig_sync_delay got=%0d want=0", state[1:0]); end
    checks++;
    tick();
    if (state[1:0] !== 2'd1) begin errors++; $display("[TB] FAIL trig_rampup got=%0d want=1", state[1:0]); end
    checks++;
    n = 0;
    while (state[1:0] !== 2'd2 && n < 400) begin tick(); n++; end
    exttrig = 1'b0;
    tick(); tick(); tick();
    if (state[1:0] !== 2'd3) begin errors++; $display("[TB] FAIL trig_rampdown got=%0d want=3", state[1:0]); end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_bypass();
    test_arith();
    test_reset_mid();
`ifdef RAMPED_REG_GATE_EXTTRIG_EN
    test_exttrig();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
